cp0_int_ctrl: RTL and testbench

- Coprocessor-0 register file and external-interrupt controller for the single-cycle MIPS core.
- Produces the exception-entry request and the return address consumed by next-PC selection: `int_req` forces the PC to 0x0000_4180, and `epc` is the target on `eret`.
- Services `mtc0`/`mfc0` from the datapath.
- Owns the SR, Cause, EPC and PrID state.

---
 rtl/cp0_pkg.sv | 17 +
 rtl/cp0_int_ctrl.sv | 85 ++++++++
 tb/tb_cp0_int_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, SR/Cause field positions and exception entry address
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  // Next-PC selection forces this address whenever int_req is high.
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

endpackage

// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 SR/Cause/EPC/PrID registers and external-interrupt request logic
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h4D49_5053,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        int_block,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic [31:0] din,
  input  logic        eret,
  output logic [31:0] dout,
  output logic        int_req,
  output logic [31:0] epc
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_q;
  logic [31:0] epc_q, epc_d;

  assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q & ~int_block & ~eret;
  assign epc     = epc_q;

  // Later assignments override earlier ones: mtc0, then eret, then interrupt entry.
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    epc_d = epc_q;
    if (we && sel == CP0_SR) begin
      im_d  = din[IM_HI:IM_LO];
      exl_d = din[EXL_BIT];
      ie_d  = din[IE_BIT];
    end
    if (we && sel == CP0_EPC) begin
      epc_d = {din[31:2], 2'b00};
    end
    if (eret) begin
      exl_d = 1'b0;
    end
    if (int_req) begin
      exl_d = 1'b1;
      epc_d = {pc[31:2], 2'b00} + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= SR_RESET[IM_HI:IM_LO];
      exl_q <= SR_RESET[EXL_BIT];
      ie_q  <= SR_RESET[IE_BIT];
      ip_q  <= 6'd0;
      epc_q <= 32'd0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      ip_q  <= hw_int;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (sel)
      CP0_SR: begin
        dout[IM_HI:IM_LO] = im_q;
        dout[EXL_BIT]     = exl_q;
        dout[IE_BIT]      = ie_q;
      end
      CP0_CAUSE: dout[IM_HI:IM_LO] = ip_q;
      CP0_EPC:   dout = epc_q;
      CP0_PRID:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - scoreboard bench for cp0_int_ctrl
module tb_cp0_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        int_block;
  logic [5:0]  hw_int;
  logic [4:0]  sel;
  logic        we;
  logic [31:0] din;
  logic        eret;
  logic [31:0] dout;
  logic        int_req;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  localparam int K_REQ  = 0;
  localparam int K_EPC  = 1;
  localparam int K_DOUT = 2;

  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  s;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  cp0_int_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc), .int_block(int_block), .hw_int(hw_int),
    .sel(sel), .we(we), .din(din), .eret(eret), .dout(dout),
    .int_req(int_req), .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input string tag, input int kind, input logic [4:0] s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.s = s; e.v = v;
    sb.push_back(e);
  endtask

  // Compare every queued expectation against the DUT as it stands now.
  task automatic drain();
    exp_t e;
    logic [4:0] sel_save;
    sel_save = sel;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REQ: chk(e.tag, {31'd0, int_req}, e.v);
        K_EPC: chk(e.tag, epc, e.v);
        default: begin
          sel = e.s;
          #1;
          chk(e.tag, dout, e.v);
        end
      endcase
    end
    sel = sel_save;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    we = 1'b1; sel = s; din = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc = 32'd0; int_block = 1'b0; hw_int = 6'd0;
    sel = 5'd0; we = 1'b0; din = 32'd0; eret = 1'b0;
    #2;
    push("rst_req", K_REQ, 5'd0, 32'd0);
    push("rst_epc", K_EPC, 5'd0, 32'd0);
    push("rst_sr", K_DOUT, 5'd12, 32'd0);
    push("rst_prid", K_DOUT, 5'd15, 32'h4D49_5053);
    drain();
    step(); step();
    reset = 1'b0;

    // basic interrupt
    mtc0(5'd12, 32'h0000_0401); pc = 32'h0000_3010;
    step();
    we = 1'b0; hw_int = 6'h01;
    push("basic_pre_req", K_REQ, 5'd0, 32'd0);
    drain();
    step();
    push("basic_req", K_REQ, 5'd0, 32'd1);
    drain();
    step();
    push("basic_post_req", K_REQ, 5'd0, 32'd0);
    push("basic_epc", K_EPC, 5'd0, 32'h0000_3014);
    push("basic_sr", K_DOUT, 5'd12, 32'h0000_0403);
    drain();

    // no nesting while EXL=1
    hw_int = 6'h3F;
    step();
    push("nest_req", K_REQ, 5'd0, 32'd0);
    drain();

    // eret with pending interrupt
    mtc0(5'd12, 32'h0000_1403); hw_int = 6'h04;
    step();
    we = 1'b0;
    step();
    pc = 32'h0000_5000; eret = 1'b1;
    push("eret_req", K_REQ, 5'd0, 32'd0);
    drain();
    step();
    eret = 1'b0;
    push("eret_epc", K_EPC, 5'd0, 32'h0000_3014);
    push("eret_sr", K_DOUT, 5'd12, 32'h0000_1401);
    push("eret_next_req", K_REQ, 5'd0, 32'd1);
    drain();
    step();
    push("eret_reentry_epc", K_EPC, 5'd0, 32'h0000_5004);
    push("eret_reentry_sr", K_DOUT, 5'd12, 32'h0000_1403);
    drain();

    // IM=0 masks everything
    mtc0(5'd12, 32'h0000_0001); hw_int = 6'h3F;
    step();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("mask_req", K_REQ, 5'd0, 32'd0);
      drain();
      step();
    end

    // unmask under int_block, then collide with mtc0 EPC
    mtc0(5'd12, 32'h0000_FC01); int_block = 1'b1; pc = 32'h0000_7000;
    step();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("block_req", K_REQ, 5'd0, 32'd0);
      drain();
      if (i < 2) step();
    end
    step();
    int_block = 1'b0;
    mtc0(5'd14, 32'h1234_5678);
    push("unblock_req", K_REQ, 5'd0, 32'd1);
    drain();
    step();
    we = 1'b0;
    push("coll_epc", K_EPC, 5'd0, 32'h0000_7004);
    drain();

    // wrap, colliding with an SR write that clears EXL
    mtc0(5'd12, 32'h0000_0401); pc = 32'hFFFF_FFFC;
    step();
    push("wrap_req", K_REQ, 5'd0, 32'd1);
    drain();
    step();
    we = 1'b0;
    push("wrap_epc", K_EPC, 5'd0, 32'h0000_0000);
    push("coll_sr", K_DOUT, 5'd12, 32'h0000_0403);
    drain();

    // mtc0 EPC with no interrupt, ignored Cause write
    hw_int = 6'h00;
    mtc0(5'd14, 32'h1234_567B);
    step();
    mtc0(5'd13, 32'hFFFF_FFFF); hw_int = 6'h3F;
    step();
    we = 1'b0;
    push("wr_epc", K_EPC, 5'd0, 32'h1234_5678);
    push("wr_epc_rd", K_DOUT, 5'd14, 32'h1234_5678);
    push("cause_rd", K_DOUT, 5'd13, 32'h0000_FC00);
    push("prid_rd", K_DOUT, 5'd15, 32'h4D49_5053);
    push("unimpl_rd", K_DOUT, 5'd3, 32'h0000_0000);
    drain();

    // asynchronous reset mid-handler
    #2;
    reset = 1'b1;
    push("mid_rst_req", K_REQ, 5'd0, 32'd0);
    push("mid_rst_epc", K_EPC, 5'd0, 32'd0);
    push("mid_rst_sr", K_DOUT, 5'd12, 32'd0);
    push("mid_rst_cause", K_DOUT, 5'd13, 32'd0);
    push("mid_rst_epc_rd", K_DOUT, 5'd14, 32'd0);
    push("mid_rst_prid", K_DOUT, 5'd15, 32'h4D49_5053);
    drain();
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
